shift_exec_seq: RTL and testbench

Multi-cycle shift execution unit for the RISC processor's shifter path. It sits directly downstream of the shift-amount stage and consumes that stage's 5-bit effective shift amount and its out-of-range bypass flag. It performs SLL, SRL, SRA or ROR on a 32-bit operand through a five-step log-shifter FSM, one binary-weighted stage per cycle, with a start/done handshake to the execute stage. Out-of-range and zero-amount shifts complete on a single-cycle fast path.

---
 rtl/shift_exec_seq.sv | 144 ++++++++++++++
 tb/tb_shift_exec_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_seq.sv
// shift_exec_seq
//   Multi-cycle shifter for the execute stage. A 32-bit operand is shifted
//   (SLL/SRL/SRA/ROR) through a five-stage log shifter, one binary-weighted
//   stage per clock. Out-of-range (non-ROR) and zero-amount requests finish
//   on a single-cycle fast path.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | stepping stage k = 4..0, one stage per cycle
//   DONE  | result valid, done pulse; a new start is accepted here
//
// Ports
//   clk_i     rising-edge clock
//   rst_n_i   synchronous active-low reset
//   start_i   request, sampled when not busy
//   op_i      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in_i operand
//   sha_i     5-bit effective shift amount
//   byp_i     amount >= 32 flag (ignored for ROR)
//   busy_o    high in SHIFT
//   done_o    one-cycle pulse with valid result
//   result_o  registered result, held until the next completion
module shift_exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [4:0]       sha_i,
  input  logic             byp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       sha_q, sha_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;

  // One log-shifter stage: shift work_q by 2^k when sha bit k is set.
  logic [5:0]       amt;
  logic [WIDTH-1:0] shl, shr, fill, stage_val;

  always_comb begin
    amt       = 6'd1 << k_q;
    shl       = work_q << amt;
    shr       = work_q >> amt;
    fill      = ~({WIDTH{1'b1}} >> amt);
    stage_val = work_q;
    if (sha_q[k_q]) begin
      case (op_q)
        OP_SLL:  stage_val = shl;
        OP_SRL:  stage_val = shr;
        OP_SRA:  stage_val = sign_q ? (shr | fill) : shr;
        default: stage_val = shr | (work_q << (6'd32 - amt));
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      k_q      <= 3'd0;
      op_q     <= 2'd0;
      sha_q    <= 5'd0;
      sign_q   <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      op_q     <= op_d;
      sha_q    <= sha_d;
      sign_q   <= sign_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    op_d     = op_q;
    sha_d    = sha_q;
    sign_d   = sign_q;
    work_d   = work_q;
    result_d = result_q;

    case (state_q)
      S_SHIFT: begin
        work_d = stage_val;
        if (k_q == 3'd0) begin
          result_d = stage_val;
          state_d  = S_DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (start_i) begin
          op_d   = op_i;
          sha_d  = sha_i;
          sign_d = data_in_i[WIDTH-1];
          work_d = data_in_i;
          if (byp_i && (op_i != OP_ROR)) begin
            result_d = (op_i == OP_SRA) ? {WIDTH{data_in_i[WIDTH-1]}} : '0;
            state_d  = S_DONE;
          end else if (sha_i == 5'd0) begin
            result_d = data_in_i;
            state_d  = S_DONE;
          end else begin
            k_d     = 3'd4;
            state_d = S_SHIFT;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign busy_o   = (state_q == S_SHIFT);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_shift_exec_seq.sv
// Scoreboard bench for shift_exec_seq: stimulus pushes the expected result
// and completion cycle; a monitor pops on every done pulse.
module tb_shift_exec_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data_in_i;
  logic [4:0]  sha_i;
  logic        byp_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  shift_exec_seq #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .data_in_i (data_in_i),
    .sha_i     (sha_i),
    .byp_i     (byp_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [31:0] last_res = 32'h0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] s, input logic b);
    logic [63:0] t;
    case (op)
      2'b00: return b ? 32'h0 : (d << s);
      2'b01: return b ? 32'h0 : (d >> s);
      2'b10: return b ? {32{d[31]}} : 32'($signed(d) >>> s);
      default: begin
        t = {d, d} >> s;
        return t[31:0];
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [4:0] s, input logic b);
    return ((b && op != 2'b11) || s == 5'd0) ? 1 : 6;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse, otherwise result must hold.
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (mon_en) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cycle=%0d result=%h", cyc, result_o);
        end else begin
          e = sb.pop_front();
          check("done_result", result_o, e.res);
          checks++;
          if (cyc != e.at) begin
            errors++;
            $display("FAIL done_cycle actual=%0d required=%0d", cyc, e.at);
          end
          last_res = e.res;
        end
      end else begin
        check("result_hold", result_o, last_res);
      end
    end
  end

  // Called at posedge+1 while the DUT is not busy.
  task automatic issue(input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] s, input logic b);
    exp_t e;
    e.res = model(op, d, s, b);
    e.at  = cyc + latency(op, s, b);
    sb.push_back(e);
    start_i   = 1'b1;
    op_i      = op;
    data_in_i = d;
    sha_i     = s;
    byp_i     = b;
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || done_o) && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL timeout_done actual=0 required=1");
    end
  endtask

  initial begin
    rst_n_i   = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    data_in_i = 32'h0;
    sha_i     = 5'd0;
    byp_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_done", {31'h0, done_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    rst_n_i = 1'b1;
    mon_en  = 1;
    @(posedge clk_i);
    #1;

    issue(2'b00, 32'h0000_0001, 5'd31, 1'b0);
    check("busy_normal", {31'h0, busy_o}, 32'h1);
    wait_idle();
    issue(2'b00, 32'h0000_0001, 5'd4, 1'b0);  wait_idle();
    issue(2'b10, 32'h8000_0000, 5'd5, 1'b0);  wait_idle();
    issue(2'b01, 32'h8000_0000, 5'd5, 1'b0);  wait_idle();
    issue(2'b00, 32'hF000_000F, 5'd7, 1'b1);
    check("busy_fast", {31'h0, busy_o}, 32'h0);
    wait_idle();
    issue(2'b10, 32'hF000_000F, 5'd7, 1'b1);  wait_idle();
    issue(2'b11, 32'hF000_000F, 5'd4, 1'b1);  wait_idle();
    issue(2'b01, 32'h1234_5678, 5'd0, 1'b0);  wait_idle();

    // start while busy must be ignored
    issue(2'b01, 32'hDEAD_BEEF, 5'd9, 1'b0);
    @(posedge clk_i);
    #1;
    start_i   = 1'b1;
    op_i      = 2'b00;
    data_in_i = 32'h5555_AAAA;
    sha_i     = 5'd0;
    byp_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_idle();

    // reset in cycle 3 of a SHIFT aborts the operation
    issue(2'b00, 32'h0000_0ABC, 5'd3, 1'b0);
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    sb.delete();
    last_res = 32'h0;
    rst_n_i  = 1'b1;
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_done", {31'h0, done_o}, 32'h0);
    check("abort_result", result_o, 32'h0);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end

    // back-to-back: each start lands in the previous done cycle
    issue(2'b00, 32'h0000_00FF, 5'd8, 1'b0);
    wait_done(); issue(2'b10, 32'h8765_4321, 5'd0, 1'b0);
    wait_done(); issue(2'b11, 32'h0000_0001, 5'd1, 1'b0);
    wait_done(); issue(2'b10, 32'h9000_0000, 5'd3, 1'b1);
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  s;
      logic        b;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      s  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b  = ($urandom_range(0, 3) == 0);
      wait_done();
      issue(op, d, s, b);
    end
    wait_idle();
    repeat (3) @(posedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
